// File: rtl/alu_nibble_sequencer_if.sv
// Requester-side bundle for the nibble sequencer.
// Carries the start/abort handshake, operands and result.
interface alu_nibble_sequencer_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic         abort;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_cin;
    logic [1:0]   op_m;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;

    modport master (
        output start, abort, op_a, op_b, op_cin, op_m,
        input  busy, done, result, carry_out
    );

    modport slave (
        input  start, abort, op_a, op_b, op_cin, op_m,
        output busy, done, result, carry_out
    );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Runs a wide operation on one shared 4-bit ALU,
// one nibble per cycle, LSB first, carry chained.
module alu_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_nibble_sequencer_if.slave bus,
    output logic [3:0]            alu_a,
    output logic [3:0]            alu_b,
    output logic                  alu_cin,
    output logic [1:0]            alu_m,
    input  logic [3:0]            alu_f,
    input  logic                  alu_cout
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [IW-1:0]  idx;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic           cin_reg;
    logic           carry_reg;
    logic [1:0]     m_reg;
    logic [W-1:0]   result_reg;
    logic           cout_reg;
    logic           busy_reg;
    logic           done_reg;

    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.result    = result_reg;
    assign bus.carry_out = cout_reg;

    // Present the current nibble to the ALU only while running.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_cin = 1'b0;
        alu_m   = '0;
        if (state == RUN) begin
            alu_a   = a_reg[4*idx +: 4];
            alu_b   = b_reg[4*idx +: 4];
            alu_cin = (idx == '0) ? cin_reg : carry_reg;
            alu_m   = m_reg;
        end
    end

    // Sequencer FSM; an aborted nibble is not written back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            cin_reg    <= 1'b0;
            carry_reg  <= 1'b0;
            m_reg      <= '0;
            result_reg <= '0;
            cout_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg    <= bus.op_a;
                        b_reg    <= bus.op_b;
                        cin_reg  <= bus.op_cin;
                        m_reg    <= bus.op_m;
                        idx      <= '0;
                        busy_reg <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        busy_reg <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        result_reg[4*idx +: 4] <= alu_f;
                        carry_reg <= alu_cout;
                        if (idx == LAST) begin
                            cout_reg <= alu_cout;
                            done_reg <= 1'b1;
                            state    <= DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    busy_reg <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy_reg <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer with a 4-bit ALU model.
// Directed vector table plus hand-written corner sequences.
module tb_alu_nibble_sequencer;
    logic       clk;
    logic       rst;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic       alu_cin;
    logic [1:0] alu_m;
    logic [3:0] alu_f;
    logic       alu_cout;

    int total;
    int passed;

    alu_nibble_sequencer_if #(.NIBBLES(4)) bus ();

    alu_nibble_sequencer #(.NIBBLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_cin  (alu_cin),
        .alu_m    (alu_m),
        .alu_f    (alu_f),
        .alu_cout (alu_cout)
    );

    // 4-bit ALU: 00 and, 01 or, 10 add, 11 a + ~b + cin.
    always_comb begin
        logic [4:0] s;
        s = 5'd0;
        unique case (alu_m)
            2'b00: s = {1'b0, alu_a & alu_b};
            2'b01: s = {1'b0, alu_a | alu_b};
            2'b10: s = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
            2'b11: s = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, alu_cin};
            default: s = 5'd0;
        endcase
        alu_f    = s[3:0];
        alu_cout = s[4];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [1:0]  m;
        logic [15:0] res;
        logic        cout;
    } vec_t;

    vec_t vecs [7];
    logic cin_log [8];
    int   nlog;
    int   cyc;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive_idle();
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        bus.op_cin = 1'b0;
        bus.op_m   = '0;
    endtask

    // Issue one op and wait (bounded) for done; cyc = start-to-done cycles.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic [1:0] m);
        @(negedge clk);
        bus.op_a   = a;
        bus.op_b   = b;
        bus.op_cin = cin;
        bus.op_m   = m;
        bus.start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        cyc  = 1;
        nlog = 0;
        while (bus.done !== 1'b1 && cyc < 20) begin
            if (nlog < 8) cin_log[nlog] = alu_cin;
            nlog++;
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int dones;
        total  = 0;
        passed = 0;
        drive_idle();
        rst = 1'b1;

        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 2'b10, 16'h0100, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 2'b10, 16'h0000, 1'b1};
        vecs[2] = '{16'h1234, 16'h4321, 1'b0, 2'b10, 16'h5555, 1'b0};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 2'b10, 16'h0000, 1'b1};
        vecs[4] = '{16'h5000, 16'h1234, 1'b1, 2'b11, 16'h3DCC, 1'b1};
        vecs[5] = '{16'h0001, 16'h0002, 1'b1, 2'b11, 16'hFFFF, 1'b0};
        vecs[6] = '{16'hF0F0, 16'h3C3C, 1'b0, 2'b00, 16'h3030, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_result", 32'(bus.result), 32'd0);
        check("reset_cout", 32'(bus.carry_out), 32'd0);
        check("reset_alu", 32'({alu_a, alu_b, alu_cin, alu_m}), 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].m);
            check($sformatf("v%0d_latency", i), 32'(cyc), 32'd5);
            check($sformatf("v%0d_result", i), 32'(bus.result),
                  32'(vecs[i].res));
            check($sformatf("v%0d_cout", i), 32'(bus.carry_out),
                  32'(vecs[i].cout));
            check($sformatf("v%0d_busy_done", i), 32'(bus.busy), 32'd1);
            if (i == 0) begin
                check("v0_cin_seq",
                      32'({cin_log[0], cin_log[1], cin_log[2], cin_log[3]}),
                      32'b0110);
            end
            @(negedge clk);
            check($sformatf("v%0d_pulse", i),
                  32'({bus.done, bus.busy}), 32'd0);
            check($sformatf("v%0d_alu_idle", i),
                  32'({alu_a, alu_b, alu_cin, alu_m}), 32'd0);
            @(negedge clk);
            check($sformatf("v%0d_hold", i), 32'(bus.result),
                  32'(vecs[i].res));
        end

        // start pulsed in RUN (cycle 2) and DONE (cycle 5): ignored
        @(negedge clk);
        bus.op_a   = 16'h8888;
        bus.op_b   = 16'h8888;
        bus.op_cin = 1'b0;
        bus.op_m   = 2'b10;
        bus.start  = 1'b1;
        @(posedge clk);
        dones = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.start = (c == 2 || c == 5);
            bus.op_a  = 16'hFFFF;
            bus.op_b  = 16'hFFFF;
            if (bus.done === 1'b1) begin
                dones++;
                check("ign_done_cycle", 32'(c), 32'd5);
            end
            if (c == 6) check("ign_busy_after", 32'(bus.busy), 32'd0);
        end
        bus.start = 1'b0;
        check("ign_done_count", 32'(dones), 32'd1);
        check("ign_result", 32'(bus.result), 32'h1110);
        check("ign_cout", 32'(bus.carry_out), 32'd1);

        // abort in third RUN cycle: nibbles 0-1 new, 2-3 prior
        @(negedge clk);
        bus.op_a   = 16'h1111;
        bus.op_b   = 16'h2222;
        bus.op_cin = 1'b0;
        bus.op_m   = 2'b10;
        bus.start  = 1'b1;
        @(posedge clk);
        dones = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.abort = (c == 3);
            if (bus.done === 1'b1) dones++;
            if (c == 4) check("abort_busy", 32'(bus.busy), 32'd0);
        end
        bus.abort = 1'b0;
        check("abort_no_done", 32'(dones), 32'd0);
        check("abort_result", 32'(bus.result), 32'h1133);
        check("abort_cout", 32'(bus.carry_out), 32'd1);

        // asynchronous reset mid-RUN
        @(negedge clk);
        bus.op_a   = 16'h1234;
        bus.op_b   = 16'h1111;
        bus.start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_result", 32'(bus.result), 32'd0);
        check("arst_cout", 32'(bus.carry_out), 32'd0);
        check("arst_alu", 32'({alu_a, alu_b, alu_cin, alu_m}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(16'h0FFF, 16'h0001, 1'b0, 2'b10);
        check("arst_after_latency", 32'(cyc), 32'd5);
        check("arst_after_result", 32'(bus.result), 32'h1000);
        check("arst_after_cout", 32'(bus.carry_out), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
